// File: rtl/regfile_sb.sv
// Multi-port register file with a load scoreboard: busy bits track outstanding
// loads, raise stall on enabled reads of pending sources, and flag stray writebacks.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   input  logic [NRD-1:0]      rd_en,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                we0,
   input  logic [AW-1:0]       waddr0,
   input  logic [XLEN-1:0]     wd0,
   input  logic                we1,
   input  logic [AW-1:0]       waddr1,
   input  logic [XLEN-1:0]     wd1,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                stall,
   output logic [AW:0]         busy_cnt,
   output logic                wb_err
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;

   // Issue beats writeback-clear so a back-to-back reload of the same register stays pending.
   always_comb begin
      busy_nxt = busy;
      busy_nxt[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         if (iss_en && iss_addr == AW'(r))
            busy_nxt[r] = 1'b1;
         else if (we1 && waddr1 == AW'(r))
            busy_nxt[r] = 1'b0;
      end
   end

   always_comb begin
      cnt_nxt = '0;
      for (int r = 0; r < NREGS; r++)
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
         if (we1 && waddr1 != '0 && !busy[waddr1])
            wb_err <= 1'b1;
      end
   end

   // Register 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (we1 && waddr1 == AW'(r))
               regs[r] <= wd1;
            else if (we0 && waddr0 == AW'(r))
               regs[r] <= wd0;
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[i*AW +: AW];

      if (BYPASS != 0) begin : g_byp
         logic hit0, hit1, hit_iss;
         assign hit0    = we0 && waddr0 == a && a != '0;
         assign hit1    = we1 && waddr1 == a && a != '0;
         assign hit_iss = iss_en && iss_addr == a;
         assign rd_data[i*XLEN +: XLEN] = hit1 ? wd1 : (hit0 ? wd0 : regs[a]);
         assign rd_busy[i] = busy[a] & ~(hit1 & ~hit_iss);
      end else begin : g_nobyp
         assign rd_data[i*XLEN +: XLEN] = regs[a];
         assign rd_busy[i] = busy[a];
      end
   end

   assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters (XLEN=32, NREGS=32, NRD=2, BYPASS=1).
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 2;
   localparam int AW = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD-1:0]      rd_en;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                we0, we1, iss_en;
   logic [AW-1:0]       waddr0, waddr1, iss_addr;
   logic [XLEN-1:0]     wd0, wd1;
   logic                stall;
   logic [AW:0]         busy_cnt;
   logic                wb_err;

   int n_checks = 0;
   int n_err = 0;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .rd_busy(rd_busy), .we0(we0), .waddr0(waddr0), .wd0(wd0), .we1(we1),
      .waddr1(waddr1), .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr),
      .stall(stall), .busy_cnt(busy_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; iss_en = 0; rst = 0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
      rd_addr = {a1, a0};
      rd_en = en;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      we0 = 0; we1 = 0; iss_en = 0; waddr0 = 0; waddr1 = 0; iss_addr = 0;
      wd0 = 0; wd1 = 0; rd_addr = 0; rd_en = 0;
      do_reset();
      #1;
      check("rst_busy_cnt", 64'(busy_cnt), 0);
      check("rst_wb_err", 64'(wb_err), 0);
      set_rd(5, 5, 2'b11); #1;
      check("rst_rd0", 64'(rd_data[31:0]), 0);
      check("rst_stall", 64'(stall), 0);

      // basic write then read; reg 0 on port 1
      we0 = 1; waddr0 = 5; wd0 = 32'hDEADBEEF;
      tick();
      idle();
      set_rd(5, 0, 2'b00); #1;
      check("wr5_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);
      check("r0_rd1", 64'(rd_data[63:32]), 0);

      // writes to reg 0 are ignored, even via bypass
      we0 = 1; waddr0 = 0; wd0 = 32'hFF; set_rd(0, 0, 2'b00); #1;
      check("r0_byp", 64'(rd_data[31:0]), 0);
      tick(); idle(); #1;
      check("r0_after", 64'(rd_data[63:32]), 0);

      // dual write same address, port 1 wins (also a stray writeback)
      we0 = 1; waddr0 = 7; wd0 = 32'h11;
      we1 = 1; waddr1 = 7; wd1 = 32'h22;
      set_rd(7, 5, 2'b00); #1;
      check("dual_byp", 64'(rd_data[31:0]), 64'h22);
      check("other_port", 64'(rd_data[63:32]), 64'hDEADBEEF);
      tick(); idle(); #1;
      check("dual_stored", 64'(rd_data[31:0]), 64'h22);
      check("dual_wb_err", 64'(wb_err), 1);

      // load issue / writeback on reg 3
      do_reset();
      iss_en = 1; iss_addr = 3; set_rd(3, 3, 2'b01); #1;
      check("iss_same_cyc_busy", 64'(rd_busy[0]), 0);
      tick(); idle(); #1;
      check("iss_busy", 64'(rd_busy[0]), 1);
      check("iss_stall", 64'(stall), 1);
      check("iss_cnt", 64'(busy_cnt), 1);
      check("iss_port1_busy", 64'(rd_busy[1]), 1);
      rd_en = 2'b00; #1;
      check("no_en_stall", 64'(stall), 0);
      rd_en = 2'b01;
      we1 = 1; waddr1 = 3; wd1 = 32'h5; #1;
      check("wb_stall", 64'(stall), 0);
      check("wb_byp", 64'(rd_data[31:0]), 64'h5);
      tick(); idle(); #1;
      check("wb_cnt", 64'(busy_cnt), 0);
      check("wb_stored", 64'(rd_data[31:0]), 64'h5);
      check("wb_no_err", 64'(wb_err), 0);

      // issue and writeback to busy reg 9 in same cycle
      iss_en = 1; iss_addr = 9; tick(); idle();
      iss_en = 1; iss_addr = 9; we1 = 1; waddr1 = 9; wd1 = 32'hAB;
      set_rd(9, 9, 2'b01); #1;
      check("isswb_same_busy", 64'(rd_busy[0]), 1);
      tick(); idle(); #1;
      check("isswb_data", 64'(rd_data[31:0]), 64'hAB);
      check("isswb_busy", 64'(rd_busy[0]), 1);
      check("isswb_cnt", 64'(busy_cnt), 1);
      check("isswb_err", 64'(wb_err), 0);
      iss_en = 1; iss_addr = 9; tick(); idle(); #1;
      check("reiss_cnt", 64'(busy_cnt), 1);
      check("reiss_err", 64'(wb_err), 0);

      // wb_err: waddr1=0 never sets, non-busy reg 4 does and sticks
      do_reset();
      we1 = 1; waddr1 = 0; wd1 = 32'h1; tick(); idle(); #1;
      check("err_r0", 64'(wb_err), 0);
      we1 = 1; waddr1 = 4; wd1 = 32'h2; tick(); idle(); #1;
      check("err_r4", 64'(wb_err), 1);
      tick(); tick(); #1;
      check("err_sticky", 64'(wb_err), 1);

      // reset beats outstanding loads and a concurrent write
      do_reset();
      for (int r = 1; r <= 3; r++) begin
         iss_en = 1; iss_addr = AW'(r); tick();
      end
      idle(); #1;
      check("cnt3", 64'(busy_cnt), 3);
      rst = 1; we0 = 1; waddr0 = 1; wd0 = 32'h77;
      tick(); idle();
      set_rd(1, 2, 2'b11); #1;
      check("rstw_rd0", 64'(rd_data[31:0]), 0);
      check("rstw_rd1", 64'(rd_data[63:32]), 0);
      check("rstw_cnt", 64'(busy_cnt), 0);
      check("rstw_stall", 64'(stall), 0);
      check("rstw_err", 64'(wb_err), 0);
      we1 = 1; waddr1 = 2; wd1 = 32'h3; tick(); idle(); #1;
      check("post_rst_err", 64'(wb_err), 1);
      check("post_rst_data", 64'(rd_data[63:32]), 64'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, >= 2; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports, 1..4.
REQ-004 Parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads, 0 = reads return stored value only.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-008 rd_en  in  NRD  read-port valid; only enabled ports contribute to stall.
REQ-009 rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]; combinational.
REQ-010 rd_busy  out  NRD  port i source has a pending load; combinational.
REQ-011 we0, waddr0, wd0  in  1/AW/XLEN  write port 0 (ALU/PC+4 result); does not touch busy bits.
REQ-012 we1, waddr1, wd1  in  1/AW/XLEN  write port 1 (load writeback); clears busy bit of waddr1.
REQ-013 iss_en, iss_addr  in  1/AW  load issue; sets busy bit of iss_addr.
REQ-014 stall  out  1  OR over i of (rd_en[i] & rd_busy[i]); combinational.
REQ-015 busy_cnt  out  AW+1  registered count of set busy bits.
REQ-016 wb_err  out  1  sticky flag: port-1 write to a non-busy, non-zero register.

Function
REQ-017 Register 0 reads as 0 on every port, ignores all writes, never becomes busy, never triggers wb_err.
REQ-018 Writes take effect at the rising edge where the enable is sampled high; new value readable from the next cycle (earlier only via bypass).
REQ-019 we0 and we1 to the same non-zero address in one cycle: wd1 stored; busy bit cleared.
REQ-020 BYPASS=1: rd_data[i] = wd1 if we1 & waddr1==rd_addr[i]!=0, else wd0 if we0 & waddr0==rd_addr[i]!=0, else stored value.
REQ-021 BYPASS=1: rd_busy[i] = 0 when we1 & waddr1==rd_addr[i] in the same cycle, unless iss_en & iss_addr==rd_addr[i] in the same cycle.
REQ-022 BYPASS=0: rd_data and rd_busy reflect registered state only.
REQ-023 Busy next state per register r!=0: set if iss_en & iss_addr==r; else cleared if we1 & waddr1==r; else held. Issue wins over clear.
REQ-024 iss_en to an already-busy register: bit stays set, busy_cnt unchanged, no error.
REQ-025 rd_busy does not reflect a same-cycle issue (issue visible from next cycle).
REQ-026 busy_cnt equals population count of the busy vector after each edge; never exceeds NREGS-1.
REQ-027 wb_err sets at the edge where we1 & waddr1!=0 & busy[waddr1]==0 & !(iss_en & iss_addr==waddr1 issued earlier); held until rst.
REQ-028 Read ports are independent; identical addresses on multiple ports return identical data and busy.

Reset
REQ-029 On rst sampled high: all registers = 0, all busy bits = 0, busy_cnt = 0, wb_err = 0.
REQ-030 rst has priority over every write, issue and clear in the same cycle; pending loads are discarded.
REQ-031 rst mid-operation: outputs reflect reset state from the cycle after the edge; a port-1 write in the first post-reset cycle to a now non-busy register sets wb_err.

Verification
REQ-032 we0=1, waddr0=5, wd0=0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF; rd_addr[1]=0 -> 0.
REQ-033 BYPASS=1: we0=1 waddr0=7 wd0=0x11, we1=1 waddr1=7 wd1=0x22, rd_addr[0]=7 same cycle -> rd_data[0]=0x22; next cycle stored 0x22.
REQ-034 iss_en iss_addr=3; next cycle rd_en[0]=1 rd_addr[0]=3 -> rd_busy[0]=1, stall=1, busy_cnt=1; we1 waddr1=3 wd1=0x5 -> with BYPASS=1 same cycle stall=0, rd_data[0]=0x5; next cycle busy_cnt=0.
REQ-035 Same cycle iss_en iss_addr=9 and we1 waddr1=9 (9 busy) -> reg 9 = wd1, busy stays 1, busy_cnt unchanged.
REQ-036 we1 waddr1=4 with reg 4 not busy -> wb_err=1 next cycle, stays 1 until rst; we1 waddr1=0 never sets it.
REQ-037 Issue regs 1..3 (busy_cnt=3), then rst with simultaneous we0 waddr0=1 -> next cycle all reads 0, busy_cnt=0, stall=0.
